cpu_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 16-bit program counter, instruction fetch, decode, ALU, data memory and register writeback for the CPU core. Each instruction advances through FETCH, DECODE, EXECUTE, optionally MEMORY, and then WRITEBACK. The block generates the PC enable/write strobes, so the PC advances or loads a branch target exactly once per retired instruction. It also detects memory handshake timeouts and counts retired instructions.

---
 rtl/cpu_sequencer_if.sv | 42 ++++
 rtl/cpu_sequencer.sv | 125 ++++++++++++
 tb/tb_cpu_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Control/handshake bundle between the CPU datapath and its sequencer.
// The slave side is the sequencer; the master side is the datapath/memory.
interface cpu_sequencer_if #(
    parameter int RETIRE_W = 16
);
    logic                I_run;
    logic                I_mem_ready;
    logic                I_halt_instr;
    logic                I_is_load;
    logic                I_is_store;
    logic                I_reg_write_req;
    logic                I_branch_taken;
    logic [2:0]          O_state;
    logic                O_pc_enable;
    logic                O_pc_write;
    logic                O_fetch_req;
    logic                O_ir_load;
    logic                O_decode_en;
    logic                O_alu_en;
    logic                O_mem_req;
    logic                O_mem_we;
    logic                O_reg_write;
    logic                O_halted;
    logic                O_fault;
    logic [RETIRE_W-1:0] O_retired;

    modport slave (
        input  I_run, I_mem_ready, I_halt_instr, I_is_load,
        input  I_is_store, I_reg_write_req, I_branch_taken,
        output O_state, O_pc_enable, O_pc_write, O_fetch_req,
        output O_ir_load, O_decode_en, O_alu_en, O_mem_req,
        output O_mem_we, O_reg_write, O_halted, O_fault, O_retired
    );

    modport master (
        output I_run, I_mem_ready, I_halt_instr, I_is_load,
        output I_is_store, I_reg_write_req, I_branch_taken,
        input  O_state, O_pc_enable, O_pc_write, O_fetch_req,
        input  O_ir_load, O_decode_en, O_alu_en, O_mem_req,
        input  O_mem_we, O_reg_write, O_halted, O_fault, O_retired
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/memory/writeback,
// memory-wait timeout into a sticky FAULT, retired-instruction counter.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input logic            I_clk,
    input logic            I_reset_n,
    cpu_sequencer_if.slave bus
);
    localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int TO_LAST_I = (MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ld_q, ld_d;
    logic                st_q, st_d;
    logic                rw_q, rw_d;
    logic                br_q, br_d;
    logic [RETIRE_W-1:0] retired_q;
    logic                timeout_hit;

    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_q      <= 1'b0;
            st_q      <= 1'b0;
            rw_q      <= 1'b0;
            br_q      <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            rw_q    <= rw_d;
            br_q    <= br_d;
            if (state_q == S_WRITEBACK)
                retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    // The wait counter only survives a cycle spent waiting in place, so
    // it is zero on every fresh entry to FETCH or MEMORY.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ld_d    = ld_q;
        st_d    = st_q;
        rw_d    = rw_q;
        br_d    = br_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.I_run)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.I_mem_ready)
                    state_d = S_DECODE;
                else if (timeout_hit)
                    state_d = S_FAULT;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            S_DECODE: begin
                ld_d    = bus.I_is_load;
                st_d    = bus.I_is_store;
                rw_d    = bus.I_reg_write_req;
                state_d = bus.I_halt_instr ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                br_d    = bus.I_branch_taken;
                state_d = (ld_q || st_q) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                if (bus.I_mem_ready)
                    state_d = S_WRITEBACK;
                else if (timeout_hit)
                    state_d = S_FAULT;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            S_WRITEBACK: begin
                state_d = bus.I_run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (!bus.I_run)
                    state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign bus.O_state     = state_q;
    assign bus.O_fetch_req = (state_q == S_FETCH);
    assign bus.O_ir_load   = (state_q == S_FETCH) && bus.I_mem_ready;
    assign bus.O_decode_en = (state_q == S_DECODE);
    assign bus.O_alu_en    = (state_q == S_EXECUTE);
    assign bus.O_mem_req   = (state_q == S_MEMORY);
    // A load+store encoding is treated as a store.
    assign bus.O_mem_we    = (state_q == S_MEMORY) && st_q;
    assign bus.O_reg_write = (state_q == S_WRITEBACK) && rw_q;
    assign bus.O_pc_enable = (state_q == S_WRITEBACK);
    assign bus.O_pc_write  = (state_q == S_WRITEBACK) && br_q;
    assign bus.O_halted    = (state_q == S_HALT);
    assign bus.O_fault     = (state_q == S_FAULT);
    assign bus.O_retired   = retired_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction flow, branch, memory
// waits, timeout fault, halt, async reset and a 4-bit retire-counter wrap.
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if #(.RETIRE_W(16)) a ();
    cpu_sequencer_if #(.RETIRE_W(4))  b ();

    assign b.I_run           = a.I_run;
    assign b.I_mem_ready     = a.I_mem_ready;
    assign b.I_halt_instr    = a.I_halt_instr;
    assign b.I_is_load       = a.I_is_load;
    assign b.I_is_store      = a.I_is_store;
    assign b.I_reg_write_req = a.I_reg_write_req;
    assign b.I_branch_taken  = a.I_branch_taken;

    cpu_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(16)) dut (
        .I_clk(clk), .I_reset_n(rst_n), .bus(a.slave)
    );

    cpu_sequencer #(.MEM_TIMEOUT(15), .RETIRE_W(4)) dut4 (
        .I_clk(clk), .I_reset_n(rst_n), .bus(b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] seq [4];
        seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd3; seq[3] = 3'd5;

        a.I_run = 1'b1;
        a.I_mem_ready = 1'b1;
        a.I_halt_instr = 1'b0;
        a.I_is_load = 1'b0;
        a.I_is_store = 1'b0;
        a.I_reg_write_req = 1'b0;
        a.I_branch_taken = 1'b0;

        @(negedge clk);
        chk("rst_state", 32'(a.O_state), 0);
        chk("rst_pc_en", 32'(a.O_pc_enable), 0);
        chk("rst_fetch", 32'(a.O_fetch_req), 0);
        chk("rst_retired", 32'(a.O_retired), 0);
        rst_n = 1'b1;

        // ALU instructions back to back
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("alu_state", 32'(a.O_state), 32'(seq[i % 4]));
            chk("alu_pc_en", 32'(a.O_pc_enable), 32'(i % 4 == 3));
            chk("alu_pc_wr", 32'(a.O_pc_write), 0);
        end
        @(negedge clk);
        chk("alu_ret3", 32'(a.O_retired), 3);
        chk("alu_fetch", 32'(a.O_state), 1);

        repeat (52) @(negedge clk);
        chk("ret16", 32'(a.O_retired), 16);
        chk("wrap4", 32'(b.O_retired), 0);
        chk("ret16_state", 32'(a.O_state), 1);

        // Branch taken in EXECUTE, dropped in WRITEBACK
        a.I_branch_taken = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("br_exec", 32'(a.O_alu_en), 1);
        @(negedge clk);
        chk("br_pc_en", 32'(a.O_pc_enable), 1);
        chk("br_pc_wr", 32'(a.O_pc_write), 1);
        a.I_branch_taken = 1'b0;
        #1;
        chk("br_pc_wr_hold", 32'(a.O_pc_write), 1);
        @(negedge clk);
        chk("br_after_en", 32'(a.O_pc_enable), 0);
        chk("br_after_wr", 32'(a.O_pc_write), 0);
        chk("br_ret", 32'(a.O_retired), 17);

        // Store with ready delayed three cycles
        a.I_is_store = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a.I_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_state", 32'(a.O_state), 4);
            chk("st_req", 32'(a.O_mem_req), 1);
            chk("st_we", 32'(a.O_mem_we), 1);
            if (k == 3) a.I_mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("st_wb", 32'(a.O_state), 5);
        chk("st_wb_req", 32'(a.O_mem_req), 0);
        chk("st_wb_rw", 32'(a.O_reg_write), 0);
        a.I_is_store = 1'b0;

        // Load with register write
        a.I_is_load = 1'b1;
        a.I_reg_write_req = 1'b1;
        @(negedge clk);
        chk("ld_f_rw", 32'(a.O_reg_write), 0);
        @(negedge clk);
        chk("ld_d_rw", 32'(a.O_reg_write), 0);
        chk("ld_dec_en", 32'(a.O_decode_en), 1);
        @(negedge clk);
        @(negedge clk);
        chk("ld_mem_req", 32'(a.O_mem_req), 1);
        chk("ld_mem_we", 32'(a.O_mem_we), 0);
        chk("ld_m_rw", 32'(a.O_reg_write), 0);
        @(negedge clk);
        chk("ld_wb_rw", 32'(a.O_reg_write), 1);
        chk("ld_wb_pc", 32'(a.O_pc_enable), 1);
        a.I_is_load = 1'b0;
        a.I_reg_write_req = 1'b0;
        a.I_run = 1'b0;
        @(negedge clk);
        chk("stop_idle", 32'(a.O_state), 0);
        chk("stop_ret", 32'(a.O_retired), 19);

        // Ready arrives on the 15th FETCH cycle
        a.I_mem_ready = 1'b0;
        a.I_run = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("to_wait", 32'(a.O_state), 1);
            if (c == 15) begin
                a.I_mem_ready = 1'b1;
                #1;
                chk("to_irload", 32'(a.O_ir_load), 1);
            end
        end
        @(negedge clk);
        chk("to_decode", 32'(a.O_state), 2);
        chk("to_nofault", 32'(a.O_fault), 0);

        // HALT decoded
        a.I_halt_instr = 1'b1;
        @(negedge clk);
        chk("halt_state", 32'(a.O_state), 6);
        chk("halt_flag", 32'(a.O_halted), 1);
        chk("halt_pc", 32'(a.O_pc_enable), 0);
        a.I_halt_instr = 1'b0;
        @(negedge clk);
        chk("halt_stay", 32'(a.O_state), 6);
        chk("halt_ret", 32'(a.O_retired), 19);
        a.I_run = 1'b0;
        @(negedge clk);
        chk("halt_idle", 32'(a.O_state), 0);
        a.I_run = 1'b1;
        @(negedge clk);
        chk("halt_refetch", 32'(a.O_state), 1);

        // Full timeout
        a.I_mem_ready = 1'b0;
        for (int c = 2; c <= 15; c++) begin
            @(negedge clk);
            chk("to_fetch", 32'(a.O_state), 1);
        end
        @(negedge clk);
        chk("fault_state", 32'(a.O_state), 7);
        chk("fault_flag", 32'(a.O_fault), 1);
        chk("fault_fetch", 32'(a.O_fetch_req), 0);
        a.I_run = 1'b0;
        @(negedge clk);
        chk("fault_run0", 32'(a.O_fault), 1);
        a.I_run = 1'b1;
        a.I_mem_ready = 1'b1;
        @(negedge clk);
        chk("fault_run1", 32'(a.O_state), 7);

        rst_n = 1'b0;
        #1;
        chk("rst2_state", 32'(a.O_state), 0);
        chk("rst2_fault", 32'(a.O_fault), 0);
        chk("rst2_ret", 32'(a.O_retired), 0);
        rst_n = 1'b1;

        // Async reset in the middle of MEMORY
        a.I_is_load = 1'b1;
        @(negedge clk);
        chk("mr_fetch", 32'(a.O_state), 1);
        @(negedge clk);
        @(negedge clk);
        a.I_mem_ready = 1'b0;
        @(negedge clk);
        chk("mr_mem", 32'(a.O_mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_state", 32'(a.O_state), 0);
        chk("mr_req", 32'(a.O_mem_req), 0);
        chk("mr_pc", 32'(a.O_pc_enable), 0);
        chk("mr_ret", 32'(a.O_retired), 0);
        chk("mr_ret4", 32'(b.O_retired), 0);
        @(negedge clk);
        chk("mr_hold", 32'(a.O_state), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
